// File: rtl/midi_wb_arbiter.sv
// midi_wb_arbiter: round-robin arbiter sharing one 8-bit Wishbone slave bus among NUM_M masters.
// Define ARB_TIMEOUT_EN to add a slave-ack timeout that terminates the transfer with m_err.
module midi_wb_arbiter #(
    parameter int NUM_M          = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_M*8-1:0] m_addr,
    input  logic [NUM_M*8-1:0] m_dat_o,
    input  logic [NUM_M-1:0]   m_we,
    input  logic [NUM_M-1:0]   m_stb,
    output logic [7:0]         m_dat_i,
    output logic [NUM_M-1:0]   m_ack,
    output logic [NUM_M-1:0]   m_err,
    output logic [7:0]         s_addr,
    output logic [7:0]         s_dat_o,
    output logic               s_we,
    output logic               s_stb,
    input  logic [7:0]         s_dat_i,
    input  logic               s_ack,
    output logic [NUM_M-1:0]   grant,
    output logic               busy
);
    localparam int LW = $clog2(NUM_M);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q, state_d;
    logic [NUM_M-1:0] grant_q, grant_d;
    logic [LW-1:0]    last_q, last_d, win;
    logic             found, in_busy, g_stb, to, done;

    generate
        if (NUM_M < 2 || NUM_M > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_param
            $error("midi_wb_arbiter: parameter out of range");
        end
    endgenerate

    // Search starts just after the last winner so every requester is reached within NUM_M grants.
    always_comb begin
        int idx;
        found = 1'b0;
        win   = '0;
        for (int k = 1; k <= NUM_M; k++) begin
            idx = (int'(last_q) + k) % NUM_M;
            if (!found && m_stb[idx]) begin
                found = 1'b1;
                win   = LW'(idx);
            end
        end
    end

    // While BUSY, last_q is the owner index and grant_q its one-hot form.
    assign in_busy = (state_q == BUSY);
    assign g_stb   = in_busy & m_stb[last_q];
    assign s_stb   = g_stb & ~to;
    assign s_we    = g_stb & m_we[last_q];
    assign s_addr  = in_busy ? m_addr[8*int'(last_q) +: 8] : 8'h00;
    assign s_dat_o = in_busy ? m_dat_o[8*int'(last_q) +: 8] : 8'h00;
    assign done    = s_stb & s_ack;
    assign m_ack   = (done | to) ? grant_q : '0;
    assign m_dat_i = to ? 8'hFF : (in_busy ? s_dat_i : 8'h00);
    assign grant   = grant_q;
    assign busy    = in_busy;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] wait_q, wait_d;

    assign to     = g_stb & ~s_ack & (wait_q == 8'(TIMEOUT_CYCLES));
    assign wait_d = in_busy ? wait_q + {7'd0, ~s_ack} : 8'd0;
    assign m_err  = to ? grant_q : '0;

    always_ff @(posedge clk) begin
        if (rst) wait_q <= 8'd0;
        else     wait_q <= wait_d;
    end
`else
    assign to    = 1'b0;
    assign m_err = '0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        if (state_q == IDLE) begin
            if (found) begin
                state_d = BUSY;
                grant_d = NUM_M'(1) << win;
                last_d  = win;
            end
        end else if (done | to | ~g_stb) begin
            state_d = IDLE;
            grant_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= LW'(NUM_M - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end
endmodule

// File: tb/tb_midi_wb_arbiter.sv
// tb_midi_wb_arbiter: directed scenarios plus randomized traffic against a behavioural arbiter model.
module tb_midi_wb_arbiter;
    localparam int TO = 8;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] m_addr = '0, m_dat_o = '0;
    logic [3:0]  m_we = '0, m_stb = '0;
    logic [7:0]  m_dat_i, s_addr, s_dat_o;
    logic [3:0]  m_ack, m_err, grant;
    logic        s_we, s_stb, busy;
    logic [7:0]  s_dat_i = '0;
    logic        s_ack = 1'b0;

    int vecs = 0;
    int errs = 0;

    midi_wb_arbiter #(.NUM_M(4), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .m_addr(m_addr), .m_dat_o(m_dat_o), .m_we(m_we), .m_stb(m_stb),
        .m_dat_i(m_dat_i), .m_ack(m_ack), .m_err(m_err), .s_addr(s_addr), .s_dat_o(s_dat_o),
        .s_we(s_we), .s_stb(s_stb), .s_dat_i(s_dat_i), .s_ack(s_ack), .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; m_stb = '0; m_we = '0; s_ack = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #2;
        vecs++;
        if ({grant, busy} !== 5'b0) begin
            errs++; $display("FAIL reset_grant_busy: got %b want 00000", {grant, busy});
        end
        vecs++;
        if ({s_stb, s_we, s_addr, s_dat_o} !== 18'b0) begin
            errs++; $display("FAIL reset_slave: got %h want 0", {s_stb, s_we, s_addr, s_dat_o});
        end
        vecs++;
        if ({m_ack, m_err, m_dat_i} !== 16'b0) begin
            errs++; $display("FAIL reset_return: got %h want 0", {m_ack, m_err, m_dat_i});
        end
        tick();
    endtask

    task automatic test_single_read;
        m_addr = 32'h0010_0000; m_stb = 4'b0100;
        #2;
        vecs++;
        if ({busy, s_stb} !== 2'b00) begin
            errs++; $display("FAIL read_req_cycle: got %b want 00", {busy, s_stb});
        end
        tick();
        #2;
        vecs++;
        if ({grant, s_stb, s_we, s_addr, m_ack} !== {4'b0100, 1'b1, 1'b0, 8'h10, 4'b0000}) begin
            errs++; $display("FAIL read_grant: got %h want %h", {grant, s_stb, s_we, s_addr, m_ack}, {4'b0100, 1'b1, 1'b0, 8'h10, 4'b0000});
        end
        tick();
        tick();
        s_ack = 1'b1; s_dat_i = 8'h5A;
        #2;
        vecs++;
        if ({m_ack, m_dat_i} !== {4'b0100, 8'h5A}) begin
            errs++; $display("FAIL read_ack: got %h want 45a", {m_ack, m_dat_i});
        end
        tick();
        s_ack = 1'b0; m_stb = '0;
        #2;
        vecs++;
        if ({m_ack, grant, busy} !== 9'b0) begin
            errs++; $display("FAIL read_after: got %b want 0", {m_ack, grant, busy});
        end
        tick();
    endtask

    task automatic test_contention;
        do_reset();
        m_stb = 4'b0011; s_ack = 1'b1; s_dat_i = 8'h33;
        #2;
        vecs++;
        if ({busy, m_ack} !== 5'b0) begin
            errs++; $display("FAIL cont_idle_ack: got %b want 0", {busy, m_ack});
        end
        tick();
        #2;
        vecs++;
        if ({grant, m_ack} !== 8'b0001_0001) begin
            errs++; $display("FAIL cont_first: got %b want 00010001", {grant, m_ack});
        end
        tick();
        m_stb = 4'b0010;
        #2;
        vecs++;
        if ({grant, busy} !== 5'b0) begin
            errs++; $display("FAIL cont_gap: got %b want 00000", {grant, busy});
        end
        tick();
        #2;
        vecs++;
        if ({grant, m_ack} !== 8'b0010_0010) begin
            errs++; $display("FAIL cont_second: got %b want 00100010", {grant, m_ack});
        end
        tick();
        m_stb = '0; s_ack = 1'b0;
        tick();
    endtask

    task automatic test_rotation;
        do_reset();
        m_stb = 4'b1111; s_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #2;
            vecs++;
            if ({grant, busy} !== 5'b0) begin
                errs++; $display("FAIL rot_gap%0d: got %b want 00000", i, {grant, busy});
            end
            tick();
            #2;
            vecs++;
            if ({grant, m_ack} !== {2{4'(1 << (i % 4))}}) begin
                errs++; $display("FAIL rot_grant%0d: got %b want %b", i, {grant, m_ack}, {2{4'(1 << (i % 4))}});
            end
            tick();
        end
        m_stb = '0; s_ack = 1'b0;
        tick();
    endtask

    task automatic test_write;
        m_addr = 32'h8000_0000; m_dat_o = 32'hC300_0000; m_we = 4'b1000; m_stb = 4'b1000;
        tick();
        #2;
        vecs++;
        if ({grant, s_stb, s_we, s_addr, s_dat_o} !== {4'b1000, 1'b1, 1'b1, 8'h80, 8'hC3}) begin
            errs++; $display("FAIL write_bus: got %h want %h", {grant, s_stb, s_we, s_addr, s_dat_o}, {4'b1000, 1'b1, 1'b1, 8'h80, 8'hC3});
        end
        s_ack = 1'b1;
        #2;
        vecs++;
        if (m_ack !== 4'b1000) begin
            errs++; $display("FAIL write_ack: got %b want 1000", m_ack);
        end
        tick();
        m_stb = '0; m_we = '0; s_ack = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid;
        m_stb = 4'b0010;
        tick();
        #2;
        vecs++;
        if ({grant, s_stb} !== 5'b0010_1) begin
            errs++; $display("FAIL rmid_busy: got %b want 00101", {grant, s_stb});
        end
        rst = 1'b1;
        tick();
        rst = 1'b0; m_stb = 4'b0011;
        #2;
        vecs++;
        if ({s_stb, grant, m_ack, busy} !== 10'b0) begin
            errs++; $display("FAIL rmid_cleared: got %b want 0", {s_stb, grant, m_ack, busy});
        end
        tick();
        #2;
        vecs++;
        if (grant !== 4'b0001) begin
            errs++; $display("FAIL rmid_next: got %b want 0001", grant);
        end
        m_stb = '0;
        tick();
        tick();
    endtask

    task automatic test_timeout;
        m_stb = 4'b0001; s_ack = 1'b0;
        tick();
        if (TO_EN) begin
            for (int k = 0; k < TO; k++) begin
                #2;
                vecs++;
                if ({m_ack, m_err, s_stb} !== 9'b0000_0000_1) begin
                    errs++; $display("FAIL to_wait%0d: got %b want 000000001", k, {m_ack, m_err, s_stb});
                end
                tick();
            end
            #2;
            vecs++;
            if ({m_ack, m_err, m_dat_i, s_stb} !== {4'b0001, 4'b0001, 8'hFF, 1'b0}) begin
                errs++; $display("FAIL to_fire: got %h want %h", {m_ack, m_err, m_dat_i, s_stb}, {4'b0001, 4'b0001, 8'hFF, 1'b0});
            end
            tick();
            #2;
            vecs++;
            if (busy !== 1'b0) begin
                errs++; $display("FAIL to_idle: got %b want 0", busy);
            end
            m_stb = '0;
        end else begin
            for (int k = 0; k < TO + 4; k++) begin
                #2;
                vecs++;
                if ({busy, m_err, s_stb} !== 6'b1_0000_1) begin
                    errs++; $display("FAIL nto_wait%0d: got %b want 100001", k, {busy, m_err, s_stb});
                end
                tick();
            end
            m_stb = '0;
            tick();
            #2;
            vecs++;
            if (busy !== 1'b0) begin
                errs++; $display("FAIL nto_abort: got %b want 0", busy);
            end
        end
        tick();
    endtask

    task automatic test_random;
        bit mb;
        int mo, ml, mc;
        bit to, sstb, done;
        logic [4:0]  e_gb;
        logic [17:0] e_sl;
        logic [15:0] e_rt;
        do_reset();
        mb = 0; ml = 3; mc = 0; mo = 0;
        for (int n = 0; n < 600; n++) begin
            m_addr  = $urandom; m_dat_o = $urandom; m_we = 4'($urandom); s_dat_i = 8'($urandom);
            if ($urandom_range(0, 3) == 0) m_stb = 4'($urandom);
            s_ack = ($urandom_range(0, 7) == 0);
            rst   = ($urandom_range(0, 63) == 0);
            #2;
            to   = TO_EN && mb && m_stb[mo] && mc == TO && !s_ack;
            sstb = mb && m_stb[mo] && !to;
            done = sstb && s_ack;
            e_gb = {mb ? 4'(1 << mo) : 4'b0, mb};
            e_sl = {sstb, mb && m_stb[mo] && m_we[mo], mb ? m_addr[8*mo +: 8] : 8'h00, mb ? m_dat_o[8*mo +: 8] : 8'h00};
            e_rt = {(done || to) ? 4'(1 << mo) : 4'b0, to ? 4'(1 << mo) : 4'b0, to ? 8'hFF : (mb ? s_dat_i : 8'h00)};
            vecs++;
            if ({grant, busy} !== e_gb) begin
                errs++; $display("FAIL rnd_grant%0d: got %b want %b", n, {grant, busy}, e_gb);
            end
            vecs++;
            if ({s_stb, s_we, s_addr, s_dat_o} !== e_sl) begin
                errs++; $display("FAIL rnd_slave%0d: got %h want %h", n, {s_stb, s_we, s_addr, s_dat_o}, e_sl);
            end
            vecs++;
            if ({m_ack, m_err, m_dat_i} !== e_rt) begin
                errs++; $display("FAIL rnd_return%0d: got %h want %h", n, {m_ack, m_err, m_dat_i}, e_rt);
            end
            if (rst) begin
                mb = 0; ml = 3; mc = 0;
            end else if (mb) begin
                if (done || to || !m_stb[mo]) mb = 0;
                else if (!s_ack) mc++;
            end else begin
                for (int k = 1; k <= 4; k++) begin
                    if (!mb && m_stb[(ml + k) % 4]) begin
                        mb = 1; mo = (ml + k) % 4; mc = 0;
                    end
                end
                if (mb) ml = mo;
            end
            tick();
        end
        rst = 1'b0; m_stb = '0; s_ack = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_rotation();
        test_write();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
